// File: rtl/imem_fetch_ctrl_if.sv
// Loader, memory-port and decode-side signals of the instruction fetch controller.
// The controller takes the slave modport; the memory/loader/decode side takes master.
interface imem_fetch_ctrl_if #(
   parameter int AW = 7
);
   logic          load_en;
   logic          load_valid;
   logic [31:0]   load_data;
   logic          load_ready;
   logic [AW:0]   load_count;

   logic          start;
   logic          halt;
   logic          stall;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic [31:0]   pc_o;
   logic [31:0]   inst_o;
   logic          inst_valid;
   logic          fault;

   modport slave (
      input  load_en, load_valid, load_data,
      input  start, halt, stall, redirect_valid, redirect_pc,
      input  mem_rdata,
      output load_ready, load_count,
      output mem_addr, mem_we, mem_wdata,
      output pc_o, inst_o, inst_valid, fault
   );

   modport master (
      output load_en, load_valid, load_data,
      output start, halt, stall, redirect_valid, redirect_pc,
      output mem_rdata,
      input  load_ready, load_count,
      input  mem_addr, mem_we, mem_wdata,
      input  pc_o, inst_o, inst_valid, fault
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: loader writes at 1 word/cycle, then one registered fetch per cycle.
// Fetch result is registered (1-cycle latency); stall holds pc and outputs, load_ready drops when memory is full.
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 128,
   parameter int          AW       = 7,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   imem_fetch_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_FAULT = 2'd3;

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [29:0] DEPTH_W   = 30'(DEPTH);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [AW:0] load_count_q, load_count_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_vld_q, inst_vld_d;
   logic        fault_q, fault_d;

   logic          load_rdy;
   logic          load_acc;
   logic [AW-1:0] mem_addr;

   // A fetch address is illegal if misaligned or past the last memory word.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W);
   endfunction

   assign load_rdy = (state_q == S_LOAD) && (load_count_q < DEPTH_CNT);
   assign load_acc = load_rdy && bus.load_valid;

   always_comb begin
      mem_addr = '0;
      if (state_q == S_LOAD) begin
         mem_addr = load_count_q[AW-1:0];
      end else if (state_q == S_RUN) begin
         mem_addr = pc_q[AW+1:2];
      end
   end

   assign bus.load_ready = load_rdy;
   assign bus.load_count = load_count_q;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_we     = load_acc;
   assign bus.mem_wdata  = load_acc ? bus.load_data : 32'h0;
   assign bus.pc_o       = pc_out_q;
   assign bus.inst_o     = inst_q;
   assign bus.inst_valid = inst_vld_q;
   assign bus.fault      = fault_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      load_count_d = load_count_q;
      pc_out_d     = pc_out_q;
      inst_d       = inst_q;
      inst_vld_d   = inst_vld_q;
      fault_d      = fault_q;

      case (state_q)
         S_IDLE: begin
            if (bus.load_en) begin
               state_d      = S_LOAD;
               load_count_d = '0;
            end else if (bus.start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
            end
         end

         S_LOAD: begin
            if (load_acc) begin
               load_count_d = load_count_q + (AW+1)'(1);
            end
            if (!bus.load_en) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            if (bus.halt) begin
               state_d    = S_IDLE;
               inst_vld_d = 1'b0;
            end else if (bus.redirect_valid) begin
               // Squash the wrong-path word; the target is checked when it is fetched.
               pc_d       = bus.redirect_pc;
               inst_vld_d = 1'b0;
            end else if (!bus.stall) begin
               if (addr_bad(pc_q)) begin
                  state_d    = S_FAULT;
                  fault_d    = 1'b1;
                  inst_vld_d = 1'b0;
               end else begin
                  inst_d     = bus.mem_rdata;
                  pc_out_d   = pc_q;
                  inst_vld_d = 1'b1;
                  pc_d       = pc_q + 32'd4;
               end
            end
         end

         default: begin
            if (bus.halt) begin
               state_d = S_IDLE;
               fault_d = 1'b0;
            end else if (bus.redirect_valid && !addr_bad(bus.redirect_pc)) begin
               state_d = S_RUN;
               pc_d    = bus.redirect_pc;
               fault_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         load_count_q <= '0;
         pc_out_q     <= '0;
         inst_q       <= '0;
         inst_vld_q   <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         load_count_q <= load_count_d;
         pc_out_q     <= pc_out_d;
         inst_q       <= inst_d;
         inst_vld_q   <= inst_vld_d;
         fault_q      <= fault_d;
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: behavioural memory, directed scenarios and a randomized fetch run
// checked against an address-level model of the program counter.
module tb_imem_fetch_ctrl;
   localparam int DEPTH = 128;
   localparam int AW    = 7;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic [31:0] img [DEPTH];
   logic [31:0] mem [DEPTH];

   imem_fetch_ctrl_if #(.AW(AW)) bus ();

   imem_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = mem[bus.mem_addr];

   function automatic bit illegal(input logic [31:0] a);
      return ((a % 32'd4) != 32'd0) || (a >= 32'(DEPTH * 4));
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.load_en        = 1'b0;
      bus.load_valid     = 1'b0;
      bus.load_data      = 32'h0;
      bus.start          = 1'b0;
      bus.halt           = 1'b0;
      bus.stall          = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      #12;
      checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", bus.load_ready); end
      checks++; if (bus.load_count !== '0) begin failures++; $display("FAIL reset_load_count got=%0d exp=0", bus.load_count); end
      checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
      checks++; if (bus.mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%0d exp=0", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
      checks++; if (bus.pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc_o got=%h exp=0", bus.pc_o); end
      checks++; if (bus.inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst_o got=%h exp=0", bus.inst_o); end
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", bus.inst_valid); end
      checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_load(input int n, input bit rnd);
      int          exp_cnt;
      logic [31:0] d;
      logic        exp_rdy;
      bus.load_en = 1'b1;
      step();
      checks++; if (bus.load_count !== '0) begin failures++; $display("FAIL load_count_clear got=%0d exp=0", bus.load_count); end
      exp_cnt = 0;
      for (int i = 0; i < n; i++) begin
         d = rnd ? $urandom : (32'h13 + 32'(i));
         bus.load_valid = 1'b1;
         bus.load_data  = d;
         #1;
         exp_rdy = (exp_cnt < DEPTH);
         checks++; if (bus.load_ready !== exp_rdy) begin failures++; $display("FAIL load_ready i=%0d got=%b exp=%b", i, bus.load_ready, exp_rdy); end
         checks++; if (bus.mem_we !== exp_rdy) begin failures++; $display("FAIL load_mem_we i=%0d got=%b exp=%b", i, bus.mem_we, exp_rdy); end
         if (exp_cnt < DEPTH) begin
            checks++; if (bus.mem_addr !== AW'(exp_cnt)) begin failures++; $display("FAIL load_mem_addr i=%0d got=%0d exp=%0d", i, bus.mem_addr, exp_cnt); end
            checks++; if (bus.mem_wdata !== d) begin failures++; $display("FAIL load_mem_wdata i=%0d got=%h exp=%h", i, bus.mem_wdata, d); end
            img[exp_cnt] = d;
            exp_cnt++;
         end
         step();
      end
      bus.load_valid = 1'b0;
      checks++; if (bus.load_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL load_count_end got=%0d exp=%0d", bus.load_count, exp_cnt); end
      bus.load_en = 1'b0;
      step();
      checks++; if (bus.load_count !== (AW+1)'(exp_cnt)) begin failures++; $display("FAIL load_count_hold got=%0d exp=%0d", bus.load_count, exp_cnt); end
      checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_idle got=%b exp=0", bus.load_ready); end
      for (int i = 0; i < exp_cnt; i++) begin
         checks++; if (mem[i] !== img[i]) begin failures++; $display("FAIL load_mem_content addr=%0d got=%h exp=%h", i, mem[i], img[i]); end
      end
   endtask

   task automatic test_run_basic();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL run_first_cycle valid got=%b exp=0", bus.inst_valid); end
      for (int k = 0; k < 8; k++) begin
         step();
         checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL run_valid k=%0d got=%b exp=1", k, bus.inst_valid); end
         checks++; if (bus.pc_o !== 32'(4 * k)) begin failures++; $display("FAIL run_pc k=%0d got=%h exp=%h", k, bus.pc_o, 4 * k); end
         checks++; if (bus.inst_o !== img[k]) begin failures++; $display("FAIL run_inst k=%0d got=%h exp=%h", k, bus.inst_o, img[k]); end
      end
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", bus.inst_valid); end
      step();
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", bus.inst_valid); end
   endtask

   task automatic test_stall();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      checks++; if (bus.pc_o !== 32'h8) begin failures++; $display("FAIL stall_pre_pc got=%h exp=8", bus.pc_o); end
      bus.stall      = 1'b1;
      bus.load_en    = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_data  = 32'hDEAD_BEEF;
      bus.start      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.mem_we !== 1'b0 || bus.load_ready !== 1'b0) begin failures++; $display("FAIL run_ignores_load k=%0d mem_we=%b load_ready=%b exp=0/0", k, bus.mem_we, bus.load_ready); end
         step();
         checks++; if (bus.pc_o !== 32'h8 || bus.inst_o !== img[2] || bus.inst_valid !== 1'b1) begin
            failures++; $display("FAIL stall_hold k=%0d got pc=%h inst=%h v=%b exp pc=8 inst=%h v=1", k, bus.pc_o, bus.inst_o, bus.inst_valid, img[2]);
         end
      end
      idle_inputs();
      step();
      checks++; if (bus.pc_o !== 32'hC || bus.inst_o !== img[3]) begin failures++; $display("FAIL stall_resume got pc=%h inst=%h exp pc=c inst=%h", bus.pc_o, bus.inst_o, img[3]); end
   endtask

   task automatic test_redirect();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      bus.stall          = 1'b1;
      step();
      idle_inputs();
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL redirect_squash got=%b exp=0", bus.inst_valid); end
      step();
      checks++; if (bus.pc_o !== 32'h40 || bus.inst_o !== img[16] || bus.inst_valid !== 1'b1) begin
         failures++; $display("FAIL redirect_target got pc=%h inst=%h v=%b exp pc=40 inst=%h v=1", bus.pc_o, bus.inst_o, bus.inst_valid, img[16]);
      end
      step();
      checks++; if (bus.pc_o !== 32'h44 || bus.inst_o !== img[17]) begin failures++; $display("FAIL redirect_next got pc=%h inst=%h exp pc=44 inst=%h", bus.pc_o, bus.inst_o, img[17]); end
   endtask

   task automatic test_fault(input logic [31:0] bad);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = bad;
      step();
      idle_inputs();
      checks++; if (bus.inst_valid !== 1'b0 || bus.fault !== 1'b0) begin failures++; $display("FAIL fault_pre tgt=%h got v=%b f=%b exp v=0 f=0", bad, bus.inst_valid, bus.fault); end
      step();
      checks++; if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL fault_set tgt=%h got f=%b v=%b exp f=1 v=0", bad, bus.fault, bus.inst_valid); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = bad;
      step();
      idle_inputs();
      step();
      checks++; if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL fault_sticky tgt=%h got f=%b v=%b exp f=1 v=0", bad, bus.fault, bus.inst_valid); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0;
      step();
      idle_inputs();
      checks++; if (bus.fault !== 1'b0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL fault_clear got f=%b v=%b exp f=0 v=0", bus.fault, bus.inst_valid); end
      step();
      checks++; if (bus.pc_o !== 32'h0 || bus.inst_o !== img[0] || bus.inst_valid !== 1'b1) begin
         failures++; $display("FAIL fault_recover got pc=%h inst=%h v=%b exp pc=0 inst=%h v=1", bus.pc_o, bus.inst_o, bus.inst_valid, img[0]);
      end
   endtask

   task automatic test_end_of_mem();
      bus.start = 1'b1;
      step();
      bus.start          = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'(DEPTH * 4 - 8);
      step();
      idle_inputs();
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (bus.pc_o !== 32'(DEPTH * 4 - 8 + 4 * k) || bus.inst_o !== img[DEPTH - 2 + k] || bus.inst_valid !== 1'b1) begin
            failures++; $display("FAIL end_fetch k=%0d got pc=%h inst=%h v=%b exp pc=%h inst=%h v=1", k, bus.pc_o, bus.inst_o, bus.inst_valid, DEPTH * 4 - 8 + 4 * k, img[DEPTH - 2 + k]);
         end
      end
      step();
      checks++; if (bus.fault !== 1'b1 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL end_fault got f=%b v=%b exp f=1 v=0", bus.fault, bus.inst_valid); end
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      checks++; if (bus.fault !== 1'b0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL halt_from_fault got f=%b v=%b exp f=0 v=0", bus.fault, bus.inst_valid); end
   endtask

   task automatic test_random_run(input int cycles);
      logic [31:0] npc, e_pc, e_inst, tgt;
      bit          e_vld, e_flt, rd, st;
      npc    = 32'h0;
      e_pc   = 32'h0;
      e_inst = 32'h0;
      e_vld  = 1'b0;
      e_flt  = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         rd = ($urandom_range(0, 99) < 8);
         st = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) != 0) tgt = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
         else if ($urandom_range(0, 1) == 1) tgt = (32'($urandom_range(0, DEPTH - 1)) * 32'd4) | 32'($urandom_range(1, 3));
         else tgt = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 32'd4;
         bus.redirect_valid = rd;
         bus.redirect_pc    = tgt;
         bus.stall          = st;
         step();
         if (e_flt) begin
            if (rd && !illegal(tgt)) begin
               e_flt = 1'b0;
               npc   = tgt;
            end
         end else if (rd) begin
            npc   = tgt;
            e_vld = 1'b0;
         end else if (!st) begin
            if (illegal(npc)) begin
               e_flt = 1'b1;
               e_vld = 1'b0;
            end else begin
               e_vld  = 1'b1;
               e_pc   = npc;
               e_inst = img[npc / 4];
               npc    = npc + 32'd4;
            end
         end
         checks++; if (bus.inst_valid !== e_vld) begin failures++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, bus.inst_valid, e_vld); end
         checks++; if (bus.fault !== e_flt) begin failures++; $display("FAIL rand_fault c=%0d got=%b exp=%b", c, bus.fault, e_flt); end
         if (e_vld) begin
            checks++; if (bus.pc_o !== e_pc || bus.inst_o !== e_inst) begin failures++; $display("FAIL rand_fetch c=%0d got pc=%h inst=%h exp pc=%h inst=%h", c, bus.pc_o, bus.inst_o, e_pc, e_inst); end
         end
      end
      idle_inputs();
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      bus.load_en = 1'b1;
      step();
      bus.load_valid = 1'b1;
      bus.load_data  = ~img[0];
      #1;
      checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL midload_we got=%b exp=1", bus.mem_we); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.mem_we !== 1'b0 || bus.load_count !== '0) begin failures++; $display("FAIL midload_reset got we=%b cnt=%0d exp we=0 cnt=0", bus.mem_we, bus.load_count); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (mem[0] !== img[0]) begin failures++; $display("FAIL midload_lost_write got=%h exp=%h", mem[0], img[0]); end
   endtask

   task automatic test_reset_mid_run();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 3; k++) step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.pc_o !== 32'h0 || bus.inst_o !== 32'h0 || bus.inst_valid !== 1'b0 || bus.fault !== 1'b0) begin
         failures++; $display("FAIL midrun_outputs got pc=%h inst=%h v=%b f=%b exp all 0", bus.pc_o, bus.inst_o, bus.inst_valid, bus.fault);
      end
      checks++; if (bus.load_ready !== 1'b0 || bus.load_count !== '0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
         failures++; $display("FAIL midrun_mem got rdy=%b cnt=%0d we=%b addr=%0d wd=%h exp all 0", bus.load_ready, bus.load_count, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk);
      #1;
      checks++; if (bus.inst_valid !== 1'b0 || bus.pc_o !== 32'h0) begin failures++; $display("FAIL midrun_held got v=%b pc=%h exp v=0 pc=0", bus.inst_valid, bus.pc_o); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL midrun_idle got v=%b exp=0", bus.inst_valid); end
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      checks++; if (bus.pc_o !== 32'h0 || bus.inst_o !== img[0] || bus.inst_valid !== 1'b1) begin
         failures++; $display("FAIL midrun_restart got pc=%h inst=%h v=%b exp pc=0 inst=%h v=1", bus.pc_o, bus.inst_o, bus.inst_valid, img[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         img[i] = 32'h0;
         mem[i] = 32'h0;
      end
      test_reset();
      test_load(39, 1'b0);
      test_run_basic();
      test_stall();
      test_redirect();
      test_fault(32'h202);
      test_fault(32'h200);
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      test_load(130, 1'b1);
      test_end_of_mem();
      test_random_run(400);
      test_reset_mid_load();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
